sw_alloc: RTL and testbench
===========================

SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 Parameter ROUTERID, default 0, router identifier; no functional effect.
REQ-002 Parameter TOUT, default 16, idle-owner timeout in cycles (range 2..255); used only with SWALLOC_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 req_0..req_4  input  1 each  input channel i requests its routed output port this cycle.
REQ-006 port_0..port_4  input  3 each  output port requested by input i; 0..4 valid, 5..7 invalid.
REQ-007 tail_0..tail_4  input  1 each  flit presented by input i is the packet tail.
REQ-008 ordy_0..ordy_4  input  1 each  output channel k has at least one free VC and can accept a new packet.
REQ-009 grt_0..grt_4  output  5 each  one-hot grant to input i; bit k set = input i owns output k.
REQ-010 busy  output  5  bit k set = output k held by an owner.

Function
REQ-011 Each output k SHALL run an independent FSM: IDLE, BUSY; plus a 3-bit owner register and a 3-bit round-robin pointer rr_k (values 0..4).
REQ-012 In IDLE, candidates for k = inputs i with req_i=1 and port_i=k; a candidate is eligible only if ordy_k=1.
REQ-013 Winner = first eligible candidate searching rr_k, rr_k+1, ... modulo 5 (4 wraps to 0).
REQ-014 On a win at edge t: state BUSY, owner=winner, grt_winner[k]=1 and busy[k]=1 visible after edge t (registered, 1-cycle latency from request).
REQ-015 Invalid port values (5..7) SHALL never produce a grant or affect any FSM.
REQ-016 In BUSY, grant held regardless of ordy_k and of other requesters; requests from non-owners ignored.
REQ-017 Release: in BUSY, if req_owner=1 and tail_owner=1 in a cycle, at the next edge state IDLE, grant bit cleared, rr_k = (owner+1) mod 5.
REQ-018 No arbitration in the release cycle; earliest new grant on k is visible two edges after the tail cycle.
REQ-019 A single-flit packet (head is tail) SHALL be granted then released per REQ-014/REQ-017 (grant high exactly one cycle when the tail is presented in that cycle).
REQ-020 Each grt_i SHALL have at most one bit set; an input is only a candidate for the single port it names.
REQ-021 Outputs evaluated in parallel; several outputs may grant different inputs on the same edge.
REQ-022 rr_k SHALL change only on release (and timeout release), never on grant.

Reset
REQ-023 On rst_=0 (asynchronous): all FSMs IDLE, owners 0, rr_k=0, grt_0..grt_4=0, busy=0, timeout counters 0.
REQ-024 Reset asserted mid-packet SHALL drop all grants immediately, without waiting for a clock edge; first grant after deassertion follows REQ-014 from rr=0.

Configuration
REQ-025 Macro SWALLOC_TIMEOUT_EN defined: per-output 8-bit counter counts consecutive BUSY cycles with req_owner=0; cleared on any cycle with req_owner=1 and on entry to BUSY; when it reaches TOUT, the next edge forces release as in REQ-017 (rr_k = owner+1).
REQ-026 Macro SWALLOC_TIMEOUT_EN undefined: no counter logic; BUSY exits only via tail release or reset.

Verification
REQ-027 Reset; req_2=1, port_2=3, ordy_3=1, tail_2=0 at cycle 0 -> grt_2=5'b01000, busy=5'b01000 after edge 1; hold for 10 cycles; tail_2=1 at cycle 10 -> grt_2=0 after edge 11, rr_3=3.
REQ-028 req_0, req_1, req_4 all to port 2, single-flit packets, held continuously, ordy_2=1 -> grant order 0,1,4,0,1,4, each grant one cycle with one idle cycle between.
REQ-029 req_3 to port 1 with ordy_1=0 for 5 cycles -> no grant; ordy_1=1 at cycle 5 -> grt_3=5'b00010 after edge 6; ordy_1 dropped while BUSY -> grant retained.
REQ-030 Inputs 0..4 to ports 4,3,2,1,0 simultaneously, all ordy=1 -> all five grants visible after the same edge, busy=5'b11111; port_1=6 alone -> no grant.
REQ-031 rst_ pulsed low mid-packet between edges -> grt_* and busy go 0 before the next edge; after release, req from input 4 alone to port 0 granted per REQ-014.
REQ-032 With SWALLOC_TIMEOUT_EN, TOUT=16: owner drops req for 16 cycles -> forced release, busy[k]=0 on the 17th edge; without the macro -> grant held indefinitely.

Source files
------------

// File: rtl/sw_alloc.sv
// sw_alloc: switch allocator for a 5-port router. Each output port runs an
// IDLE/BUSY FSM with a round-robin pointer and grants itself to one input
// for the duration of a packet (head to tail).
// Optional build macro SWALLOC_TIMEOUT_EN: forced release of an output whose
// owner has stopped requesting for TOUT consecutive cycles.
module sw_alloc #(
  parameter int ROUTERID = 0,
  parameter int TOUT     = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  input  logic       req_4,
  input  logic [2:0] port_0,
  input  logic [2:0] port_1,
  input  logic [2:0] port_2,
  input  logic [2:0] port_3,
  input  logic [2:0] port_4,
  input  logic       tail_0,
  input  logic       tail_1,
  input  logic       tail_2,
  input  logic       tail_3,
  input  logic       tail_4,
  input  logic       ordy_0,
  input  logic       ordy_1,
  input  logic       ordy_2,
  input  logic       ordy_3,
  input  logic       ordy_4,
  output logic [4:0] grt_0,
  output logic [4:0] grt_1,
  output logic [4:0] grt_2,
  output logic [4:0] grt_3,
  output logic [4:0] grt_4,
  output logic [4:0] busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state    [5];
  state_t     state_nx [5];
  logic [2:0] owner    [5];
  logic [2:0] owner_nx [5];
  logic [2:0] rr       [5];
  logic [2:0] rr_nx    [5];
`ifdef SWALLOC_TIMEOUT_EN
  logic [7:0] cnt      [5];
  logic [7:0] cnt_nx   [5];
`endif

  logic [4:0] req;
  logic [4:0] tail;
  logic [4:0] ordy;
  logic [2:0] port [5];
  logic [4:0] held;
  logic [4:0] cand [5];
  logic [4:0] grt  [5];

  assign req  = {req_4, req_3, req_2, req_1, req_0};
  assign tail = {tail_4, tail_3, tail_2, tail_1, tail_0};
  assign ordy = {ordy_4, ordy_3, ordy_2, ordy_1, ordy_0};
  assign port[0] = port_0;
  assign port[1] = port_1;
  assign port[2] = port_2;
  assign port[3] = port_3;
  assign port[4] = port_4;

  assign grt_0 = grt[0];
  assign grt_1 = grt[1];
  assign grt_2 = grt[2];
  assign grt_3 = grt[3];
  assign grt_4 = grt[4];

  // Grants/busy decoded from registered state; candidate vectors per output.
  // An input already owning an output is not a candidate elsewhere, which
  // keeps every grt_i one-hot even if it re-targets mid-packet.
  always_comb begin
    busy = '0;
    held = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      grt[i] = '0;
      for (int unsigned k = 0; k < 5; k++)
        grt[i][k] = (state[k] == BUSY) && (owner[k] == 3'(i));
      held[i] = |grt[i];
    end
    for (int unsigned k = 0; k < 5; k++) begin
      busy[k] = (state[k] == BUSY);
      cand[k] = '0;
      for (int unsigned i = 0; i < 5; i++)
        cand[k][i] = req[i] && (port[i] == 3'(k)) && ordy[k] && !held[i];
    end
  end

  // Per-output next state: round-robin arbitration in IDLE, release in BUSY.
  always_comb begin
    for (int unsigned k = 0; k < 5; k++) begin
      logic found;
      logic rel;
      int unsigned idx;
      found       = 1'b0;
      rel         = 1'b0;
      idx         = 0;
      state_nx[k] = state[k];
      owner_nx[k] = owner[k];
      rr_nx[k]    = rr[k];
`ifdef SWALLOC_TIMEOUT_EN
      cnt_nx[k]   = cnt[k];
`endif
      case (state[k])
        IDLE: begin
          for (int unsigned off = 0; off < 5; off++) begin
            idx = (32'(rr[k]) + off) % 5;
            if (!found && cand[k][idx]) begin
              found       = 1'b1;
              state_nx[k] = BUSY;
              owner_nx[k] = idx[2:0];
            end
          end
`ifdef SWALLOC_TIMEOUT_EN
          cnt_nx[k] = '0;
`endif
        end
        BUSY: begin
          rel = req[owner[k]] && tail[owner[k]];
`ifdef SWALLOC_TIMEOUT_EN
          if (req[owner[k]])
            cnt_nx[k] = '0;
          else if (cnt[k] != 8'hFF)
            cnt_nx[k] = cnt[k] + 8'd1;
          if (cnt[k] == 8'(TOUT))
            rel = 1'b1;
`endif
          if (rel) begin
            state_nx[k] = IDLE;
            rr_nx[k]    = (owner[k] == 3'd4) ? 3'd0 : owner[k] + 3'd1;
`ifdef SWALLOC_TIMEOUT_EN
            cnt_nx[k]   = '0;
`endif
          end
        end
        default: state_nx[k] = IDLE;
      endcase
    end
  end

  // State registers; asynchronous reset drops every grant at once.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int unsigned k = 0; k < 5; k++) begin
        state[k] <= IDLE;
        owner[k] <= '0;
        rr[k]    <= '0;
`ifdef SWALLOC_TIMEOUT_EN
        cnt[k]   <= '0;
`endif
      end
    end else begin
      for (int unsigned k = 0; k < 5; k++) begin
        state[k] <= state_nx[k];
        owner[k] <= owner_nx[k];
        rr[k]    <= rr_nx[k];
`ifdef SWALLOC_TIMEOUT_EN
        cnt[k]   <= cnt_nx[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc: directed bench for sw_alloc; expected {grants,busy} words are
// queued as stimulus is applied and compared after each clock edge.
module tb_sw_alloc;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       req_0 = 0, req_1 = 0, req_2 = 0, req_3 = 0, req_4 = 0;
  logic [2:0] port_0 = 0, port_1 = 0, port_2 = 0, port_3 = 0, port_4 = 0;
  logic       tail_0 = 0, tail_1 = 0, tail_2 = 0, tail_3 = 0, tail_4 = 0;
  logic       ordy_0 = 0, ordy_1 = 0, ordy_2 = 0, ordy_3 = 0, ordy_4 = 0;
  logic [4:0] grt_0, grt_1, grt_2, grt_3, grt_4, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [29:0] sb [$];

  sw_alloc #(.ROUTERID(0), .TOUT(16)) dut (
    .clk(clk), .rst_(rst_),
    .req_0(req_0), .req_1(req_1), .req_2(req_2), .req_3(req_3), .req_4(req_4),
    .port_0(port_0), .port_1(port_1), .port_2(port_2), .port_3(port_3), .port_4(port_4),
    .tail_0(tail_0), .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3), .tail_4(tail_4),
    .ordy_0(ordy_0), .ordy_1(ordy_1), .ordy_2(ordy_2), .ordy_3(ordy_3), .ordy_4(ordy_4),
    .grt_0(grt_0), .grt_1(grt_1), .grt_2(grt_2), .grt_3(grt_3), .grt_4(grt_4),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Word layout: busy in [4:0], grt_i in [5*i+9 : 5*i+5].
  function automatic logic [29:0] g(input int i, input int k);
    logic [29:0] w;
    w = '0;
    w[5 + 5*i + k] = 1'b1;
    w[k] = 1'b1;
    return w;
  endfunction

  task automatic compare(input string tag);
    logic [29:0] obs, exp;
    obs = {grt_4, grt_3, grt_2, grt_1, grt_0, busy};
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic now(input logic [29:0] exp, input string tag);
    sb.push_back(exp);
    compare(tag);
  endtask

  task automatic cyc(input logic [29:0] exp, input string tag);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic clear_in();
    {req_0, req_1, req_2, req_3, req_4} = '0;
    {tail_0, tail_1, tail_2, tail_3, tail_4} = '0;
    {port_0, port_1, port_2, port_3, port_4} = '0;
    {ordy_0, ordy_1, ordy_2, ordy_3, ordy_4} = '0;
  endtask

  initial begin
    int order [6];
    logic [29:0] all5;
    order = '{0, 1, 4, 0, 1, 4};

    // reset state
    #2 now('0, "reset");
    #2 rst_ = 1'b1;

    // single input, multi-flit packet on output 3
    req_2 = 1; port_2 = 3; ordy_3 = 1;
    cyc(g(2, 3), "grant_2_3");
    for (int c = 1; c < 10; c++) cyc(g(2, 3), "hold_2_3");
    tail_2 = 1;
    cyc('0, "release_2_3");
    // rr_3 must now be 3: inputs 2,3,4 all contend, 3 wins
    tail_2 = 0; req_3 = 1; port_3 = 3; req_4 = 1; port_4 = 3;
    cyc(g(3, 3), "rr3_after_release");
    req_2 = 0; req_4 = 0; tail_3 = 1;
    cyc('0, "release_3_3");
    clear_in();

    // three single-flit requesters on output 2, round robin
    req_0 = 1; req_1 = 1; req_4 = 1; port_0 = 2; port_1 = 2; port_4 = 2;
    tail_0 = 1; tail_1 = 1; tail_4 = 1; ordy_2 = 1;
    for (int n = 0; n < 6; n++) begin
      cyc(g(order[n], 2), "rr_grant");
      cyc('0, "rr_gap");
    end
    clear_in();

    // ordy gating of a fresh grant, then retention while busy
    req_3 = 1; port_3 = 1;
    for (int c = 0; c < 5; c++) cyc('0, "ordy_block");
    ordy_1 = 1;
    cyc(g(3, 1), "ordy_grant");
    ordy_1 = 0; req_0 = 1; port_0 = 1;
    for (int c = 0; c < 3; c++) cyc(g(3, 1), "busy_retain");
    tail_3 = 1;
    cyc('0, "release_3_1");
    clear_in();

    // all five outputs granted on the same edge
    req_0 = 1; req_1 = 1; req_2 = 1; req_3 = 1; req_4 = 1;
    port_0 = 4; port_1 = 3; port_2 = 2; port_3 = 1; port_4 = 0;
    {ordy_0, ordy_1, ordy_2, ordy_3, ordy_4} = '1;
    all5 = g(0, 4) | g(1, 3) | g(2, 2) | g(3, 1) | g(4, 0);
    cyc(all5, "parallel_all");
    {tail_0, tail_1, tail_2, tail_3, tail_4} = '1;
    cyc('0, "parallel_release");
    clear_in();

    // invalid port numbers
    {ordy_0, ordy_1, ordy_2, ordy_3, ordy_4} = '1;
    req_1 = 1; port_1 = 6;
    for (int c = 0; c < 3; c++) cyc('0, "invalid_6");
    port_1 = 5; req_0 = 1; port_0 = 7;
    cyc('0, "invalid_5_7");
    clear_in();

    // asynchronous reset mid-packet
    req_2 = 1; port_2 = 0; ordy_0 = 1;
    cyc(g(2, 0), "pre_reset_grant");
    #2 rst_ = 1'b0;
    req_2 = 0;
    #1 now('0, "async_reset");
    #2 rst_ = 1'b1;
    req_4 = 1; port_4 = 0;
    cyc(g(4, 0), "post_reset_grant");

    // owner stops requesting
    req_4 = 0;
`ifdef SWALLOC_TIMEOUT_EN
    for (int c = 0; c < 16; c++) cyc(g(4, 0), "timeout_hold");
    cyc('0, "timeout_release");
`else
    for (int c = 0; c < 20; c++) cyc(g(4, 0), "idle_owner_hold");
    req_4 = 1; tail_4 = 1;
    cyc('0, "tail_release_4_0");
`endif
    clear_in();
    cyc('0, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
